// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache, 2^INDEX_W lines of four 32-bit words with line refill.
// Define ICACHE_PERF_EN to add the perf_hit/perf_miss lookup counters.
module icache_dm #(
    parameter int INDEX_W  = 8,
    parameter int TAG_W    = 20,
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [INDEX_W-1:0]  req_index,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic [OFFSET_W-1:0] req_offset,
    output logic                resp_valid,
    output logic [31:0]         resp_inst,
    input  logic                flush,
    output logic                rd_req,
    output logic [31:0]         rd_addr,
    input  logic                rd_rdy,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [31:0]         ret_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]         perf_hit,
    output logic [31:0]         perf_miss
`endif
);

    localparam int LINES = 1 << INDEX_W;

    typedef logic [3:0][31:0] line_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_RESP
    } state_t;

    // Arrays are deliberately not reset; only the valid bits are.
    line_t              data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_q;

    state_t             state_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [1:0]         woff_q;
    logic               lk_vld_q;
    logic [TAG_W-1:0]   lk_tag_q;
    line_t              lk_line_q;
    logic [1:0]         beat_q;
    logic               pend_q;
    logic [31:0]        resp_q;
    logic               rd_req_q;
    logic [31:0]        rd_addr_q;
`ifdef ICACHE_PERF_EN
    logic [31:0]        perf_hit_q;
    logic [31:0]        perf_miss_q;
`endif

    logic hit;
    logic accept;
    logic unused_off;

    assign unused_off = ^req_offset[1:0];

    assign hit        = (state_q == S_LOOKUP) && lk_vld_q && (lk_tag_q == tag_q);
    assign req_ready  = !rst && ((state_q == S_IDLE) || hit);
    assign accept     = req_valid && req_ready;
    assign resp_valid = hit || (state_q == S_RESP);
    assign resp_inst  = hit ? lk_line_q[woff_q] : resp_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
`ifdef ICACHE_PERF_EN
    assign perf_hit   = perf_hit_q;
    assign perf_miss  = perf_miss_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            lk_vld_q  <= 1'b0;
            beat_q    <= 2'd0;
            pend_q    <= 1'b0;
            resp_q    <= 32'd0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= 32'd0;
`ifdef ICACHE_PERF_EN
            perf_hit_q  <= 32'd0;
            perf_miss_q <= 32'd0;
`endif
        end else begin
            // A request accepted alongside a flush must look up against the flushed state.
            if (accept) begin
                tag_q     <= req_tag;
                idx_q     <= req_index;
                woff_q    <= req_offset[3:2];
                lk_vld_q  <= valid_q[req_index] && !flush;
                lk_tag_q  <= tag_mem[req_index];
                lk_line_q <= data_mem[req_index];
            end
            case (state_q)
                S_IDLE: begin
                    if (flush) valid_q <= '0;
                    if (req_valid) state_q <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (flush) valid_q <= '0;
                    if (hit) begin
`ifdef ICACHE_PERF_EN
                        perf_hit_q <= perf_hit_q + 32'd1;
`endif
                        state_q <= req_valid ? S_LOOKUP : S_IDLE;
                    end else begin
`ifdef ICACHE_PERF_EN
                        perf_miss_q <= perf_miss_q + 32'd1;
`endif
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= 32'({tag_q, idx_q, 4'b0000});
                        state_q   <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (flush) pend_q <= 1'b1;
                    if (rd_rdy) begin
                        rd_req_q <= 1'b0;
                        beat_q   <= 2'd0;
                        state_q  <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (flush) pend_q <= 1'b1;
                    if (ret_valid) begin
                        if (beat_q == woff_q) resp_q <= ret_data;
                        beat_q <= beat_q + 2'd1;
                        if (ret_last) begin
                            // A flush seen during the miss wipes the freshly written line as well.
                            if (pend_q || flush) valid_q <= '0;
                            else                 valid_q[idx_q] <= 1'b1;
                            pend_q  <= 1'b0;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (flush) valid_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_REFILL) && ret_valid) begin
            data_mem[idx_q][beat_q] <= ret_data;
            if (ret_last) tag_mem[idx_q] <= tag_q;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm: a line-level cache model predicts hit/miss and every response cycle.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_index = '0;
    logic [19:0] req_tag = '0;
    logic [3:0]  req_offset = '0;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        flush = 1'b0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last = 1'b0;
    logic [31:0] ret_data = '0;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    icache_dm dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_tag(req_tag), .req_offset(req_offset),
        .resp_valid(resp_valid), .resp_inst(resp_inst),
        .flush(flush),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
`ifdef ICACHE_PERF_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit miss_pending = 0;

    typedef struct {
        int          cyc;
        logic [31:0] w;
    } exp_t;
    exp_t        expq[$];
    logic [31:0] resp_log[$];

    // Line-level model of the cache contents
    bit          mvalid[256];
    logic [19:0] mtag[256];
    logic [31:0] mdata[256][4];
    int          mhit = 0;
    int          mmiss = 0;
    logic [31:0] last_rd_addr = '0;
    bit          rd_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) mvalid[i] = 0;
    endtask

    // Backing memory image; the cold-miss line carries the hand-chosen beats 0x11..0x44.
    function automatic logic [31:0] memword(input logic [19:0] t, input logic [7:0] i, input logic [1:0] w);
        if (t == 20'h1C000 && i == 8'h00) return 32'h11 * (32'(w) + 32'd1);
        return {t[11:0], i, 10'(w), 2'b01} ^ 32'h5A3C_96E1;
    endfunction

    // Every cycle: a response exactly when the model scheduled one, never a stray refill request.
    always @(negedge clk) begin
        if (chk_en) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL resp_missing: wanted pulse in cycle %0d, still absent at %0d", expq[0].cyc, cyc);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_inst", resp_inst, expq[0].w);
                resp_log.push_back(resp_inst);
                void'(expq.pop_front());
            end else begin
                chk("resp_quiet", 32'(resp_valid), 32'd0);
            end
            if (!miss_pending) chk("rd_req_quiet", 32'(rd_req), 32'd0);
        end
    end

    task automatic do_req(input logic [19:0] t, input logic [7:0] i, input logic [3:0] o,
                          input bit fl_req, input int fl_beat, input int rst_after);
        logic [31:0] exp_addr;
        bit          hit;
        bit          fl_seen;
        exp_t        e;
        exp_addr   = {t, i, 4'h0};
        rd_seen    = 0;
        req_valid  = 1'b1;
        req_tag    = t;
        req_index  = i;
        req_offset = o;
        for (int k = 0; k < 20 && !req_ready; k++) step();
        if (!req_ready) begin
            fail_to("req_ready");
            req_valid = 1'b0;
            return;
        end
        flush = fl_req;
        if (fl_req) clear_model();
        hit = mvalid[i] && (mtag[i] == t);
        if (hit) begin
            e.cyc = cyc + 1;
            e.w   = mdata[i][o[3:2]];
            expq.push_back(e);
            mhit++;
        end else begin
            mmiss++;
            miss_pending = 1;
        end
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        if (hit) return;
        for (int k = 0; k < 10 && !rd_req; k++) step();
        if (!rd_req) begin
            fail_to("rd_req");
            miss_pending = 0;
            return;
        end
        rd_seen      = 1;
        last_rd_addr = rd_addr;
        chk("rd_addr", rd_addr, exp_addr);
        repeat ($urandom_range(0, 3)) begin
            step();
            chk("rd_req_hold", 32'(rd_req), 32'd1);
            chk("rd_addr_hold", rd_addr, exp_addr);
        end
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        miss_pending = 0;
        fl_seen = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == rst_after) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                clear_model();
                mhit  = 0;
                mmiss = 0;
                ret_valid = 1'b1;
                ret_last  = 1'b1;
                ret_data  = $urandom;
                step();
                ret_valid = 1'b0;
                ret_last  = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 2)) step();
            ret_valid = 1'b1;
            ret_last  = (b == 3);
            ret_data  = memword(t, i, 2'(b));
            flush     = (b == fl_beat);
            if (b == fl_beat) fl_seen = 1;
            mdata[i][b] = ret_data;
            if (b == 3) begin
                e.cyc = cyc + 1;
                e.w   = memword(t, i, o[3:2]);
                expq.push_back(e);
            end
            step();
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            flush     = 1'b0;
        end
        mtag[i] = t;
        if (fl_seen) clear_model();
        else         mvalid[i] = 1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        clear_model();
        step();
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ret_valid = 1'($urandom_range(0, 1));
            ret_last  = ret_valid;
            ret_data  = $urandom;
            step();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] tags[4];
        logic [7:0]  idxs[4];
        int          n0;
        tags = '{20'h1C000, 20'h1C001, 20'hABCDE, 20'h00001};
        idxs = '{8'h00, 8'h01, 8'h02, 8'hFF};
        clear_model();

        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_inst", resp_inst, 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk_en = 1;

        // Cold miss
        do_req(20'h1C000, 8'h00, 4'h8, 0, -1, -1);
        step();
        chk("cold_miss_seen", 32'(rd_seen), 32'd1);
        chk("cold_rd_addr", last_rd_addr, 32'h1C000000);
        chk("cold_resp", resp_log[$], 32'h33);

        // Back-to-back hits on the filled line
        n0 = resp_log.size();
        do_req(20'h1C000, 8'h00, 4'h0, 0, -1, -1);
        do_req(20'h1C000, 8'h00, 4'h4, 0, -1, -1);
        do_req(20'h1C000, 8'h00, 4'hC, 0, -1, -1);
        step();
        chk("hit_count", 32'(resp_log.size() - n0), 32'd3);
        chk("hit_w0", resp_log[n0], 32'h11);
        chk("hit_w1", resp_log[n0 + 1], 32'h22);
        chk("hit_w3", resp_log[n0 + 2], 32'h44);

        // Conflict in index 0 evicts the first line
        do_req(20'h1C001, 8'h00, 4'h0, 0, -1, -1);
        chk("conflict_rd_addr", last_rd_addr, 32'h1C001000);
        do_req(20'h1C000, 8'h00, 4'h4, 0, -1, -1);
        step();
        chk("reevict_miss_seen", 32'(rd_seen), 32'd1);
        chk("reevict_rd_addr", last_rd_addr, 32'h1C000000);
        chk("reevict_resp", resp_log[$], 32'h22);
`ifdef ICACHE_PERF_EN
        chk("perf_hit_3", perf_hit, 32'd3);
        chk("perf_miss_3", perf_miss, 32'd3);
`endif

        // Flush during refill: word still returned, line not retained
        do_req(20'h00ABC, 8'h05, 4'h4, 0, 1, -1);
        do_req(20'h00ABC, 8'h05, 4'h4, 0, -1, -1);
        chk("flush_refill_remiss", 32'(rd_seen), 32'd1);

        // Reset after two beats, then stray return beats
        step();
        n0 = resp_log.size();
        do_req(20'h00DEF, 8'h07, 4'hC, 0, -1, 2);
        idle(2);
        chk("rst_refill_no_resp", 32'(resp_log.size()), 32'(n0));
        do_req(20'h00DEF, 8'h07, 4'hC, 0, -1, -1);
        chk("rst_refill_remiss", 32'(rd_seen), 32'd1);

        // Request coinciding with a flush misses even on a resident line
        do_req(20'h00DEF, 8'h07, 4'h0, 0, -1, -1);
        chk("resident_hit_no_refill", 32'(rd_seen), 32'd0);
        do_req(20'h00DEF, 8'h07, 4'h0, 1, -1, -1);
        chk("flush_with_req_miss", 32'(rd_seen), 32'd1);

        for (int n = 0; n < 300; n++) begin
            int r;
            logic [7:0] ri;
            r  = $urandom_range(0, 19);
            ri = ($urandom_range(0, 4) == 4) ? 8'($urandom) : idxs[$urandom_range(0, 3)];
            if (r < 15)
                do_req(tags[$urandom_range(0, 3)], ri, 4'($urandom), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1, -1);
            else if (r < 17)
                do_flush();
            else if (r < 19)
                idle($urandom_range(0, 2));
            else
                do_req(tags[$urandom_range(0, 3)], ri, 4'($urandom), 0, -1, int'($urandom_range(0, 3)));
        end

        idle(3);
        chk("queue_drained", 32'(expq.size()), 32'd0);
`ifdef ICACHE_PERF_EN
        chk("perf_hit_end", perf_hit, 32'(mhit));
        chk("perf_miss_end", perf_miss, 32'(mmiss));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache that consumes the physical index/tag/offset triple produced by the MMU instruction-address path.
- Returns one 32-bit instruction to IF per accepted request.
- On a miss, fetches the whole line from the memory bridge through a request/return refill interface.
- Default geometry: 4 KB total, 256 lines of 16 bytes (4 words).

Parameters:
- INDEX_W, 8, line index width; number of lines = 2^INDEX_W.
- TAG_W, 20, physical tag width.
- OFFSET_W, 4, byte offset within a line; fixed at 4, giving 4 words per line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  IF fetch request
- req_ready  out  1  cache can accept a request this cycle
- req_index  in  INDEX_W  line index from MMU
- req_tag  in  TAG_W  physical tag from MMU
- req_offset  in  OFFSET_W  byte offset; [3:2] selects the word, [1:0] ignored
- resp_valid  out  1  single-cycle pulse; instruction valid
- resp_inst  out  32  fetched instruction
- flush  in  1  invalidate all lines
- rd_req  out  1  line refill request
- rd_addr  out  32  {tag, index, 4'b0}, line-aligned
- rd_rdy  in  1  memory accepted rd_req
- ret_valid  in  1  refill beat valid
- ret_last  in  1  final refill beat
- ret_data  in  32  refill beat data

Behaviour:
- Storage: valid[2^INDEX_W], tag array, data array of 4x32 per line. Valid bits cleared by rst; tag and data arrays are not reset.
- Reset values: req_ready=0 during rst and 1 in the first cycle after. resp_valid=0, resp_inst=0, rd_req=0, rd_addr=0. FSM=IDLE, beat counter=0, pending-flush=0.
- FSM states: IDLE, LOOKUP, MISS, REFILL, RESP.
- IDLE:
  - req_ready=1.
  - req_valid: latch tag/index/offset and read the arrays; next state LOOKUP.
- LOOKUP:
  - hit = valid[idx] && tag[idx]==latched tag.
  - Hit: resp_valid=1 and resp_inst = word[offset[3:2]] in this cycle (1-cycle latency after acceptance). req_ready=1, so a new request may be accepted in the same cycle (stay LOOKUP); otherwise go to IDLE. Back-to-back hits give 1 instruction per cycle.
  - Miss: req_ready=0; next state MISS.
- MISS:
  - rd_req=1 with rd_addr held stable until rd_rdy=1.
  - rd_req && rd_rdy: clear the beat counter; next state REFILL.
- REFILL:
  - Each ret_valid writes ret_data to word[beat] of the line, then beat increments (wraps mod 4).
  - The beat equal to offset[3:2] is captured into the response register.
  - ret_valid && ret_last: write tag, set valid, next state RESP. This completes the line even if fewer than 4 beats were seen; unwritten words are undefined.
  - ret_valid=0 stalls indefinitely.
- RESP:
  - resp_valid=1 with the captured word; req_ready=0; next state IDLE.
- resp_valid is never asserted in IDLE, MISS or REFILL.
- resp has no backpressure; IF must sink every pulse.
- Flush:
  - In IDLE or LOOKUP: all valid bits cleared at the next edge. A LOOKUP response in that same cycle still uses pre-flush state.
  - In MISS or REFILL: sets pending-flush. At the ret_last edge, the line write occurs and all valid bits, including the new line, are cleared. The RESP word is still returned. Pending-flush is then cleared.
- Simultaneous req_valid and flush in IDLE: request accepted; its lookup sees all lines invalid and misses.
- rst mid-refill: FSM returns to IDLE and valid bits clear. Later stray ret_valid/ret_last are ignored outside REFILL.
- ret_valid outside REFILL: ignored.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs perf_hit[31:0] and perf_miss[31:0], both 0 on rst.
  - perf_hit increments on each LOOKUP hit; perf_miss increments on each LOOKUP miss.
  - Counters wrap at 2^32 and are unaffected by flush.
- Undefined: no perf ports and no counter logic.

Test Plan:
- Cold miss:
  - Stimulus: after rst, request tag=0x1C000, index=0x00, offset=0x8; rd_rdy=1 the same cycle; beats 0x11,0x22,0x33,0x44 with ret_last on beat 4.
  - Expected: rd_addr=0x1C000000; resp_valid one cycle after ret_last with resp_inst=0x33.
- Hit after fill:
  - Stimulus: same tag/index, offsets 0x0, 0x4, 0xC issued back-to-back.
  - Expected: three consecutive resp_valid pulses 0x11, 0x22, 0x44, each 1 cycle after acceptance; rd_req stays 0.
- Conflict:
  - Stimulus: tag=0x1C001, index=0x00.
  - Expected: miss with rd_addr=0x1C001000; afterwards tag 0x1C000 misses again.
- Flush during refill:
  - Stimulus: assert flush for 1 cycle in REFILL.
  - Expected: requested word still returned; an immediate re-request to the same address misses.
- Reset mid-REFILL:
  - Stimulus: rst after 2 beats, followed by stray ret_valid/ret_last.
  - Expected: no resp_valid; valid bits clear; the next request misses.
- ICACHE_PERF_EN:
  - Stimulus: the first three scenarios.
  - Expected: perf_hit=3, perf_miss=3.
